fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined MIPS. It owns the program counter and drives the instruction memory's read address. It captures the returned word into the IF/ID pipeline register, and honours stall, redirect (branch/jump/JR resolved downstream) and HALT. It sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
Parameters:
- n, 16, datapath/address width; PC and instruction width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit request; hold PC and IF/ID.
- redirect_valid  input  1  downstream taken branch/jump/JR; also squashes the IF/ID contents.
- redirect_pc  input  n  target PC, valid with redirect_valid.
- inst  input  n  instruction word from instruction memory (combinational read).
- pc_out  output  n  current PC; connects to the instruction memory read_address.
- if_id_inst  output  n  registered instruction to decode.
- if_id_pc_plus1  output  n  registered PC+1 of that instruction (branch base, JAL link).
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped on HALT.

## Operation
- Opcode is inst[n-1:n-4]. HALT=4'hF, NOP=4'hE, J=4'hB, JAL=4'hC.
- Bubble encoding: if_id_inst=16'hE000 (NOP), if_id_valid=0.
- States: RUN and HALTED.
- RUN, per-edge priority (highest first):
  1. redirect_valid: pc<=redirect_pc; IF/ID<=bubble.
  2. stall: pc and IF/ID hold.
  3. inst opcode HALT: IF/ID<=HALT word with valid=1 and pc_plus1; pc holds at the HALT address; go HALTED.
  4. Otherwise: pc<=pc+1; IF/ID<={inst, pc+1, valid=1}.
- HALTED:
  - pc and halted=1 hold.
  - IF/ID<=bubble each non-stalled edge.
  - redirect_valid: pc<=redirect_pc, IF/ID<=bubble, go RUN, halted<=0. This covers a wrong-path HALT squashed by an older branch.
  - stall holds everything.
- Arithmetic: pc+1 is modulo 2^n; 16'hFFFF wraps to 16'h0000. No flag is raised.
- A redirect in the same cycle as a HALT fetch discards the HALT: the state stays RUN.
- Reset mid-operation clears everything immediately; fetch restarts at 0.

## Timing
- Reset values:
  - pc_out=0.
  - if_id_inst=16'hE000.
  - if_id_pc_plus1=0.
  - if_id_valid=0.
  - halted=0.
  - State RUN.
- pc_out is a direct register output, with no combinational path from inputs.
- inst is sampled in the same cycle pc_out is presented. IF/ID is updated at the next rising edge: 1-cycle fetch latency.
- Redirect penalty: 1 bubble in IF/ID. The target instruction appears in IF/ID 2 edges after redirect_valid is sampled.
- stall has no effect on outputs until the edge. If stall is held N cycles, pc and IF/ID are frozen for N edges.
- halted asserts at the edge that captures HALT into IF/ID.

## Configuration
- Macro: FETCH_EARLY_JUMP_EN.
- Defined:
  - In RUN, not stalled, no redirect, and inst opcode is J or JAL: pc<={pc_plus1[n-1:12], inst[11:0]}.
  - IF/ID still captures the J/JAL with valid=1 and pc_plus1 (needed for the JAL link).
  - Downstream must not redirect for J/JAL. Jump penalty is 0 bubbles.
- Undefined: J/JAL are fetched sequentially (pc<=pc+1). The downstream redirect resolves them with a 1-bubble penalty.

## Test plan
- Sequential fetch and async reset:
  - ROM holds ADDI words at 0..3 -> pc_out 0,1,2,3; if_id_pc_plus1 1,2,3; if_id_valid=1.
  - Drop rst_n mid-cycle -> pc_out=0, if_id_inst=16'hE000, valid=0 immediately, without waiting for an edge.
- Stall: assert stall 3 cycles with pc=2 -> pc_out stays 2 and IF/ID stays unchanged for 3 edges. Release -> pc_out=3.
- Redirect with stall: assert redirect_valid=1, redirect_pc=16'h0008 and stall=1 in the same cycle -> pc_out=8 next edge, if_id_valid=0, if_id_inst=16'hE000.
- Halt and resume:
  - HALT at 0x0005 -> halted=1 and pc_out=5 after the edge; if_id_inst=16'hF000; bubbles thereafter.
  - redirect to 16'h0003 -> halted=0, pc_out=3.
- Wrap: force pc to 16'hFFFF via redirect, with ADDI at both addresses -> next pc_out=16'h0000, if_id_pc_plus1=16'h0000.
- Early jump:
  - Place {J,12'h008} at 0x0005.
  - With FETCH_EARLY_JUMP_EN -> pc_out=8 after the edge, IF/ID holds J with pc_plus1=6.
  - Without the macro -> pc_out=6.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory address, fills IF/ID.
// Optional macro FETCH_EARLY_JUMP_EN resolves J/JAL in fetch with zero bubbles.
module fetch_stage #(
    parameter int unsigned n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    input  logic [n-1:0] inst,
    output logic [n-1:0] pc_out,
    output logic [n-1:0] if_id_inst,
    output logic [n-1:0] if_id_pc_plus1,
    output logic         if_id_valid,
    output logic         halted
);

    localparam int unsigned OP_W = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;
    localparam logic [n-1:0]    NOP_WORD = {4'hE, {(n - OP_W){1'b0}}};

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t          state;
    logic [OP_W-1:0] opcode_c;
    logic [n-1:0]    pc_plus1_c;
    logic [n-1:0]    seq_pc_c;

    assign opcode_c   = inst[n-1 -: OP_W];
    assign pc_plus1_c = pc_out + n'(1);

    // Next PC for a normal (non-HALT) fetch
`ifdef FETCH_EARLY_JUMP_EN
    localparam logic [OP_W-1:0] OP_J   = 4'hB;
    localparam logic [OP_W-1:0] OP_JAL = 4'hC;

    always_comb begin
        seq_pc_c = pc_plus1_c;
        if (opcode_c == OP_J || opcode_c == OP_JAL) begin
            seq_pc_c = {pc_plus1_c[n-1:12], inst[11:0]};
        end
    end
`else
    assign seq_pc_c = pc_plus1_c;
`endif

    // PC, IF/ID register and RUN/HALTED control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            pc_out         <= '0;
            if_id_inst     <= NOP_WORD;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        pc_out      <= redirect_pc;
                        if_id_inst  <= NOP_WORD;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_inst     <= inst;
                        if_id_pc_plus1 <= pc_plus1_c;
                        if_id_valid    <= 1'b1;
                        if (opcode_c == OP_HALT) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc_out <= seq_pc_c;
                        end
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc_out      <= redirect_pc;
                        if_id_inst  <= NOP_WORD;
                        if_id_valid <= 1'b0;
                        state       <= RUN;
                        halted      <= 1'b0;
                    end else if (!stall) begin
                        if_id_inst  <= NOP_WORD;
                        if_id_valid <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: ROM-backed reference model compared every cycle plus directed literal checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] inst;
    logic [15:0] pc_out;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;

    logic [15:0] rom [0:65535];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(.n(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst           (inst),
        .pc_out         (pc_out),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    // instruction memory: combinational read
    assign inst = rom[pc_out];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: architectural fetch behaviour
    logic [15:0] m_pc, m_inst, m_pp1;
    logic        m_valid, m_halted;

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] fetched;
        logic [15:0] nxt;
        if (!rst_n) begin
            m_pc = 16'h0000; m_inst = 16'hE000; m_pp1 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0;
        end else begin
            fetched = rom[m_pc];
            nxt     = m_pc + 16'd1;
            if (redirect_valid) begin
                m_pc = redirect_pc; m_inst = 16'hE000; m_valid = 1'b0; m_halted = 1'b0;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (m_halted) begin
                m_inst = 16'hE000; m_valid = 1'b0;
            end else begin
                m_inst = fetched; m_pp1 = nxt; m_valid = 1'b1;
                if (fetched[15:12] == 4'hF) begin
                    m_halted = 1'b1;
                end
`ifdef FETCH_EARLY_JUMP_EN
                else if (fetched[15:12] == 4'hB || fetched[15:12] == 4'hC) begin
                    m_pc = {nxt[15:12], fetched[11:0]};
                end
`endif
                else begin
                    m_pc = nxt;
                end
            end
        end
        #1;
        check("model_pc", pc_out, m_pc);
        check("model_inst", if_id_inst, m_inst);
        check("model_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        check("model_halted", {15'd0, halted}, {15'd0, m_halted});
        if (m_valid) check("model_pp1", if_id_pc_plus1, m_pp1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 16'hE000;
        rom[0] = 16'h4101; rom[1] = 16'h4202; rom[2] = 16'h4303;
        rom[3] = 16'h4404; rom[4] = 16'h4505; rom[5] = 16'hF000;
        rom[8] = 16'h4808; rom[9] = 16'h4909; rom[16'hFFFF] = 16'h4F0F;
        rom[16'h0020] = 16'hF000; rom[16'h0030] = 16'h4A0A;

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_pc", pc_out, 16'h0000);
        check("rst_inst", if_id_inst, 16'hE000);
        check("rst_pp1", if_id_pc_plus1, 16'h0000);
        check("rst_valid", {15'd0, if_id_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        rst_n = 1'b1;

        // sequential fetch
        @(negedge clk);
        check("seq1_pc", pc_out, 16'h0001);
        check("seq1_inst", if_id_inst, 16'h4101);
        check("seq1_pp1", if_id_pc_plus1, 16'h0001);
        check("seq1_valid", {15'd0, if_id_valid}, 16'd1);
        @(negedge clk);
        check("seq2_pc", pc_out, 16'h0002);
        check("seq2_pp1", if_id_pc_plus1, 16'h0002);

        // stall three cycles
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_pc", pc_out, 16'h0002);
            check("stall_inst", if_id_inst, 16'h4202);
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_pc", pc_out, 16'h0003);
        check("unstall_inst", if_id_inst, 16'h4303);
        check("unstall_pp1", if_id_pc_plus1, 16'h0003);
        repeat (2) @(negedge clk);
        check("pre_halt_pc", pc_out, 16'h0005);

        // halt
        @(negedge clk);
        check("halt_flag", {15'd0, halted}, 16'd1);
        check("halt_pc", pc_out, 16'h0005);
        check("halt_inst", if_id_inst, 16'hF000);
        check("halt_pp1", if_id_pc_plus1, 16'h0006);
        check("halt_valid", {15'd0, if_id_valid}, 16'd1);
        stall = 1'b1;
        @(negedge clk);
        check("halt_stall_inst", if_id_inst, 16'hF000);
        stall = 1'b0;
        @(negedge clk);
        check("halt_bubble_inst", if_id_inst, 16'hE000);
        check("halt_bubble_valid", {15'd0, if_id_valid}, 16'd0);
        check("halt_hold_pc", pc_out, 16'h0005);

        // resume from halt
        redirect_valid = 1'b1; redirect_pc = 16'h0003;
        @(negedge clk);
        check("resume_halted", {15'd0, halted}, 16'd0);
        check("resume_pc", pc_out, 16'h0003);

        // redirect wins over stall
        redirect_pc = 16'h0008; stall = 1'b1;
        @(negedge clk);
        check("rdst_pc", pc_out, 16'h0008);
        check("rdst_valid", {15'd0, if_id_valid}, 16'd0);
        check("rdst_inst", if_id_inst, 16'hE000);
        redirect_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("target_pc", pc_out, 16'h0009);
        check("target_inst", if_id_inst, 16'h4808);

        // wrap
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        check("wrap_pre_pc", pc_out, 16'hFFFF);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_pc", pc_out, 16'h0000);
        check("wrap_pp1", if_id_pc_plus1, 16'h0000);
        check("wrap_inst", if_id_inst, 16'h4F0F);

        // redirect in the same cycle as a HALT fetch
        redirect_valid = 1'b1; redirect_pc = 16'h0020;
        @(negedge clk);
        check("rdhalt_pre_pc", pc_out, 16'h0020);
        redirect_pc = 16'h0030;
        @(negedge clk);
        check("rdhalt_halted", {15'd0, halted}, 16'd0);
        check("rdhalt_pc", pc_out, 16'h0030);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rdhalt_run_pc", pc_out, 16'h0031);
        check("rdhalt_run_inst", if_id_inst, 16'h4A0A);

        // jump fetch
        rom[5] = 16'hB008;
        redirect_valid = 1'b1; redirect_pc = 16'h0005;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_EARLY_JUMP_EN
        check("jump_pc", pc_out, 16'h0008);
`else
        check("jump_pc", pc_out, 16'h0006);
`endif
        check("jump_inst", if_id_inst, 16'hB008);
        check("jump_pp1", if_id_pc_plus1, 16'h0006);
        check("jump_valid", {15'd0, if_id_valid}, 16'd1);
        @(negedge clk);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", pc_out, 16'h0000);
        check("arst_inst", if_id_inst, 16'hE000);
        check("arst_valid", {15'd0, if_id_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_pc", pc_out, 16'h0001);
        check("restart_inst", if_id_inst, 16'h4101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
